// File: rtl/mc_core_pkg.sv
// Shared opcodes, FSM state encoding and instruction field helpers for mc_core_p.
package mc_core_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_JMP   = 3'b010;
    localparam logic [2:0] OP_BZ    = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_ADDI  = 3'b110;
    localparam logic [2:0] OP_MOVTO = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    // Layout: opcode in the top 3 bits, register index below it, immediate in the rest.
    function automatic int imm_w(input int dw, input int ridx_w);
        return dw - 3 - ridx_w;
    endfunction

    function automatic int ri_lo(input int dw, input int ridx_w);
        return imm_w(dw, ridx_w);
    endfunction

    function automatic int op_lo(input int dw);
        return dw - 3;
    endfunction

endpackage

// File: rtl/mc_core_regfile.sv
// Register file: R0 read port fixed, one indexed read port, one synchronous write port.
module mc_core_regfile
    import mc_core_pkg::*;
#(
    parameter int DW     = 16,
    parameter int NREG   = 8,
    parameter int RIDX_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RIDX_W-1:0] ra2,
    output logic [DW-1:0]     rd1,
    output logic [DW-1:0]     rd2,
    input  logic              we,
    input  logic [RIDX_W-1:0] wa,
    input  logic [DW-1:0]     wd
);

    logic [NREG-1:0][DW-1:0] regs;

    assign rd1 = regs[0];
    assign rd2 = regs[ra2];

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '0;
        else if (we)
            regs[wa] <= wd;
    end

endmodule

// File: rtl/mc_core_p.sv
// Multi-cycle accumulator core with a stallable req/ready memory port.
// Optional MC_CORE_PERF_EN adds instret and stall_cnt counters.
module mc_core_p
    import mc_core_pkg::*;
#(
    parameter int                DW       = 16,
    parameter int                NREG     = 8,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_ready,
    input  logic [DW-1:0]     mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              zero
`ifdef MC_CORE_PERF_EN
    ,
    output logic [31:0]       instret,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int RIDX_W = $clog2(NREG);
    localparam int IMM_W  = imm_w(DW, RIDX_W);
    localparam int RI_LO  = ri_lo(DW, RIDX_W);
    localparam int OP_LO  = op_lo(DW);

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [DW-1:0]     ir, a_q, b_q, alu_q, mdr_q;

    logic [2:0]        op;
    logic [RIDX_W-1:0] ri;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] imm_addr;
    logic [DW-1:0]     imm_sx;

    logic              rf_we;
    logic [RIDX_W-1:0] rf_wa;
    logic [DW-1:0]     rf_wd, rf_rd1, rf_rd2;

    assign op       = ir[OP_LO +: 3];
    assign ri       = ir[RI_LO +: RIDX_W];
    assign imm      = ir[IMM_W-1:0];
    assign imm_addr = ADDR_W'(imm);
    assign imm_sx   = {{(DW-IMM_W){imm[IMM_W-1]}}, imm};

    // Port outputs decode from the state register only; address and data come
    // from IR/PC/A which are frozen while the request waits, so they stay stable.
    assign mem_req   = !rst && (state == S_FETCH || state == S_MEM);
    assign mem_we    = !rst && state == S_MEM && op == OP_STORE;
    assign mem_addr  = (state == S_MEM) ? imm_addr : pc_q;
    assign mem_wdata = a_q;
    assign pc        = pc_q;
    assign zero      = (rf_rd1 == '0);

    assign retire = !rst && ((state == S_WB) ||
                             (state == S_EXEC && (op == OP_JMP || op == OP_BZ)) ||
                             (state == S_MEM && op == OP_STORE && mem_ready));

    assign rf_we = !rst && state == S_WB;
    assign rf_wa = (op == OP_MOVTO) ? ri : '0;
    assign rf_wd = (op == OP_MOVTO) ? a_q : (op == OP_LOAD) ? mdr_q : alu_q;

    mc_core_regfile #(.DW(DW), .NREG(NREG), .RIDX_W(RIDX_W)) u_rf (
        .clk (clk),
        .rst (rst),
        .ra2 (ri),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (rf_wd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc_q  <= RESET_PC;
            ir    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr_q <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q   <= rf_rd1;
                    b_q   <= rf_rd2;
                    pc_q  <= pc_q + ADDR_W'(1);
                    state <= (op == OP_LOAD || op == OP_STORE) ? S_MEM : S_EXEC;
                end
                S_EXEC: begin
                    case (op)
                        OP_ADD:   begin alu_q <= a_q + b_q;    state <= S_WB; end
                        OP_SUB:   begin alu_q <= a_q - b_q;    state <= S_WB; end
                        OP_ADDI:  begin alu_q <= a_q + imm_sx; state <= S_WB; end
                        OP_MOVTO: state <= S_WB;
                        OP_JMP:   begin pc_q <= imm_addr; state <= S_FETCH; end
                        OP_BZ: begin
                            if (a_q == '0)
                                pc_q <= imm_addr;
                            state <= S_FETCH;
                        end
                        default:  state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op == OP_STORE) begin
                            state <= S_FETCH;
                        end else begin
                            mdr_q <= mem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB:    state <= S_FETCH;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MC_CORE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            instret   <= '0;
            stall_cnt <= '0;
        end else begin
            if (retire)
                instret <= instret + 32'd1;
            if (mem_req && !mem_ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_core_p.sv
// Directed bench for mc_core_p: memory model, write scoreboard and retire timing.
module tb_mc_core_p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, zero;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, pc;
`ifdef MC_CORE_PERF_EN
    logic [31:0] instret, stall_cnt;
`endif

    logic [15:0] mem [0:255];
    logic        ready = 1'b1;
    int          ncmp = 0;
    int          nfail = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          ret_q[$];
    logic [31:0] wr_exp[$];

    assign mem_ready = ready;
    assign mem_rdata = mem[mem_addr[7:0]];

    mc_core_p #(.DW(16), .NREG(8), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .pc        (pc),
        .retire    (retire),
        .zero      (zero)
`ifdef MC_CORE_PERF_EN
        ,
        .instret   (instret),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Edge bookkeeping plus the write scoreboard.
    always @(posedge clk) begin
        cyc++;
        if (!rst && retire)
            ret_q.push_back(cyc);
        if (!rst && mem_req && mem_ready && mem_we) begin
            check("wr_pending", 32'(wr_exp.size() != 0), 32'd1);
            if (wr_exp.size() != 0)
                check("wr_addr_data", {mem_addr, mem_wdata}, wr_exp.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ret(input int k, input int budget);
        int n = 0;
        while (ret_q.size() < k && n < budget) begin
            step();
            n++;
        end
        check("retire_count", 32'(ret_q.size() >= k), 32'd1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++)
            mem[i] = 16'h0000;
    endtask

    // Reset for a few edges, release mid-cycle, t0 = first edge after release.
    task automatic do_reset(input logic rdy);
        rst = 1'b1;
        ready = 1'b1;
        repeat (2) step();
        ret_q.delete();
        ready = rdy;
        rst = 1'b0;
        step();
        t0 = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state and first request
        clear_mem();
        mem[0] = 16'hC005;
        mem[1] = 16'h2020;
        mem[2] = 16'h4002;
        rst = 1'b1;
        repeat (3) step();
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_retire", 32'(retire), 32'd0);
        ret_q.delete();
        rst = 1'b0;
        #1;
        check("idle_req", 32'(mem_req), 32'd0);
        step();
        t0 = cyc;
        check("first_req", {15'd0, mem_req, mem_addr}, 32'h0001_0000);

        // Zero-wait ADDI then STORE
        wr_exp.push_back({16'h0020, 16'h0005});
        wait_ret(2, 30);
        check("addi_latency", 32'(ret_q[0] - t0), 32'd4);
        check("store_latency", 32'(ret_q[1] - ret_q[0]), 32'd3);
        check("pc_after_store", 32'(pc), 32'h0002);
        check("store_seen", 32'(wr_exp.size()), 32'd0);
`ifdef MC_CORE_PERF_EN
        check("instret", instret, 32'd2);
`endif

        // Fetch stalled for 3 cycles
        do_reset(1'b0);
        check("stall_req0", {15'd0, mem_req, mem_addr}, 32'h0001_0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold", {15'd0, mem_req, mem_we, mem_addr}, 32'h0002_0000);
        end
        ready = 1'b1;
        wr_exp.push_back({16'h0020, 16'h0005});
        wait_ret(2, 30);
        check("stall_addi_latency", 32'(ret_q[0] - t0), 32'd7);
        check("stall_store_latency", 32'(ret_q[1] - ret_q[0]), 32'd3);
        check("stall_store_seen", 32'(wr_exp.size()), 32'd0);
`ifdef MC_CORE_PERF_EN
        check("stall_cnt", stall_cnt, 32'd3);
`endif

        // SUB wraps below zero
        clear_mem();
        mem[0] = 16'hC001;
        mem[1] = 16'hE400;
        mem[2] = 16'hC3FF;
        mem[3] = 16'hA400;
        mem[4] = 16'h2021;
        mem[5] = 16'h4005;
        do_reset(1'b1);
        wr_exp.push_back({16'h0021, 16'hFFFF});
        wait_ret(1, 30);
        check("zero_after_addi1", 32'(zero), 32'd0);
        wait_ret(3, 30);
        check("zero_after_addim1", 32'(zero), 32'd1);
        wait_ret(4, 30);
        check("zero_after_sub", 32'(zero), 32'd0);
        wait_ret(5, 30);
        check("sub_store_seen", 32'(wr_exp.size()), 32'd0);

        // BZ taken, then not taken
        clear_mem();
        mem[16'h00] = 16'h6010;
        mem[16'h10] = 16'hC005;
        mem[16'h11] = 16'h6020;
        mem[16'h12] = 16'h4012;
        do_reset(1'b1);
        wait_ret(1, 30);
        check("bz_taken_addr", {15'd0, mem_req, mem_addr}, 32'h0001_0010);
        wait_ret(3, 30);
        check("bz_fall_addr", {15'd0, mem_req, mem_addr}, 32'h0001_0012);

        // Reset while a STORE is stalled
        clear_mem();
        mem[0] = 16'hC005;
        mem[1] = 16'h2020;
        mem[2] = 16'h4002;
        do_reset(1'b1);
        wait_ret(1, 30);
        step();
        ready = 1'b0;
        step();
        check("store_pending", {30'd0, mem_req, mem_we}, 32'd3);
        check("store_wdata", 32'(mem_wdata), 32'h0005);
        repeat (2) step();
        rst = 1'b1;
        step();
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_pc", 32'(pc), 32'h0000);
        check("abort_zero", 32'(zero), 32'd1);
        check("abort_retire", 32'(retire), 32'd0);
        ready = 1'b1;
        repeat (2) step();
        check("abort_no_write", 32'(wr_exp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
